// File: rtl/mire_gen.sv
// Wishbone test-pattern writer: fills an HDISP x VDISP RGB565 framebuffer with
// one of four patterns, in bursts of BURST acked writes separated by PAUSE idle cycles.
module mire_gen #(
  parameter int          HDISP    = 640,
  parameter int          VDISP    = 480,
  parameter logic [31:0] BASE_ADR = 32'h0,
  parameter int          GRID     = 16,
  parameter int          BURST    = 64,
  parameter int          PAUSE    = 64
) (
  input  logic        wshb_clk_i,
  input  logic        wshb_rst_i,
  output logic [31:0] wshb_adr_o,
  output logic [15:0] wshb_dat_ms_o,
  output logic        wshb_stb_o,
  output logic        wshb_cyc_o,
  input  logic        wshb_ack_i,
  output logic        wshb_we_o,
  output logic [1:0]  wshb_sel_o,
  output logic [2:0]  wshb_cti_o,
  output logic [1:0]  wshb_bte_o,
  input  logic        en_i,
  input  logic [1:0]  mode_i,
  input  logic [15:0] color_i,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam int XW   = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW   = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int IW   = $clog2(HDISP * VDISP);
  localparam int GW   = $clog2(GRID);
  localparam int BW   = $clog2(BURST + 1);
  localparam int PW   = $clog2(PAUSE + 1);
  localparam int BARW = XW + 3;

  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GRID - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BURST - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PAUSE - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_PAUSE} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [GW-1:0] xg_q, xg_d, yg_q, yg_d;
  logic          xc_q, xc_d, yc_q, yc_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [15:0]   color_q, color_d;
  logic          done_q, done_d;
  logic          pos_clr, pos_adv, last_px;

  assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

  always_ff @(posedge wshb_clk_i or posedge wshb_rst_i) begin
    if (wshb_rst_i) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      xg_q    <= '0;
      yg_q    <= '0;
      xc_q    <= 1'b0;
      yc_q    <= 1'b0;
      burst_q <= '0;
      pcnt_q  <= '0;
      mode_q  <= 2'd0;
      color_q <= 16'h0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      xg_q    <= xg_d;
      yg_q    <= yg_d;
      xc_q    <= xc_d;
      yc_q    <= yc_d;
      burst_q <= burst_d;
      pcnt_q  <= pcnt_d;
      mode_q  <= mode_d;
      color_q <= color_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    xg_d    = xg_q;
    yg_d    = yg_q;
    xc_d    = xc_q;
    yc_d    = yc_q;
    burst_d = burst_q;
    pcnt_d  = pcnt_q;
    mode_d  = mode_q;
    color_d = color_q;
    done_d  = 1'b0;
    pos_clr = 1'b0;
    pos_adv = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          mode_d  = mode_i;
          color_d = color_i;
          pos_clr = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wshb_ack_i) begin
          if (last_px) begin
            done_d  = 1'b1;
            pos_clr = 1'b1;
            if (en_i) begin
              mode_d  = mode_i;
              color_d = color_i;
              state_d = S_PAUSE;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            pos_adv = 1'b1;
            if (burst_q == B_LAST) state_d = S_PAUSE;
          end
        end
      end
      S_PAUSE: begin
        if (pcnt_q == P_LAST) begin
          pcnt_d  = '0;
          burst_d = '0;
          state_d = S_WRITE;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Grid/checker phase is tracked incrementally alongside X and Y to avoid dividers.
    if (pos_clr) begin
      x_d     = '0;
      y_d     = '0;
      idx_d   = '0;
      xg_d    = '0;
      yg_d    = '0;
      xc_d    = 1'b0;
      yc_d    = 1'b0;
      burst_d = '0;
    end else if (pos_adv) begin
      idx_d   = idx_q + IW'(1);
      burst_d = burst_q + BW'(1);
      if (x_q == X_LAST) begin
        x_d  = '0;
        xg_d = '0;
        xc_d = 1'b0;
        y_d  = y_q + YW'(1);
        if (yg_q == G_LAST) begin
          yg_d = '0;
          yc_d = ~yc_q;
        end else begin
          yg_d = yg_q + GW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
        if (xg_q == G_LAST) begin
          xg_d = '0;
          xc_d = ~xc_q;
        end else begin
          xg_d = xg_q + GW'(1);
        end
      end
    end
  end

  function automatic logic [15:0] bar_color(input logic [2:0] bar);
    case (bar)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction

  logic [BARW-1:0] xs;
  logic [2:0]      bar;

  // floor(X*8/HDISP) as seven threshold compares; valid because X < HDISP.
  always_comb begin
    xs  = {x_q, 3'b000};
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (xs >= BARW'(k * HDISP)) bar = 3'(k);
    end
  end

  always_comb begin
    case (mode_q)
      2'd0:    wshb_dat_ms_o = ((xg_q == '0) || (yg_q == '0)) ? 16'hFFFF : 16'h0000;
      2'd1:    wshb_dat_ms_o = bar_color(bar);
      2'd2:    wshb_dat_ms_o = (xc_q ^ yc_q) ? 16'h0000 : 16'hFFFF;
      default: wshb_dat_ms_o = color_q;
    endcase
  end

  assign wshb_adr_o   = BASE_ADR + 32'({idx_q, 1'b0});
  assign wshb_cyc_o   = (state_q == S_WRITE);
  assign wshb_stb_o   = (state_q == S_WRITE);
  assign wshb_we_o    = 1'b1;
  assign wshb_sel_o   = 2'b11;
  assign wshb_cti_o   = 3'b000;
  assign wshb_bte_o   = 2'b00;
  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_mire_gen.sv
// Bench for mire_gen: a frame/pixel-level reference model predicts every output each cycle.
module tb_mire_gen;
  localparam int          H  = 8;
  localparam int          V  = 4;
  localparam int          G  = 4;
  localparam int          B  = 4;
  localparam int          P  = 2;
  localparam logic [31:0] BA = 32'h100;

  logic        clk = 1'b0;
  logic        rst, en, ack;
  logic [1:0]  mode;
  logic [15:0] color;
  logic [31:0] adr;
  logic [15:0] dat;
  logic        stb, cyc, we, busy, done;
  logic [1:0]  sel, bte;
  logic [2:0]  cti;

  mire_gen #(
    .HDISP(H), .VDISP(V), .BASE_ADR(BA), .GRID(G), .BURST(B), .PAUSE(P)
  ) dut (
    .wshb_clk_i    (clk),
    .wshb_rst_i    (rst),
    .wshb_adr_o    (adr),
    .wshb_dat_ms_o (dat),
    .wshb_stb_o    (stb),
    .wshb_cyc_o    (cyc),
    .wshb_ack_i    (ack),
    .wshb_we_o     (we),
    .wshb_sel_o    (sel),
    .wshb_cti_o    (cti),
    .wshb_bte_o    (bte),
    .en_i          (en),
    .mode_i        (mode),
    .color_i       (color),
    .busy_o        (busy),
    .frame_done_o  (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 writing, 2 pausing
  int          m_st, m_pix, m_win, m_pl, m_mode, m_frames, dut_frames;
  logic [15:0] m_color;
  bit          m_done;

  function automatic logic [15:0] pat(input int md, input logic [15:0] c, input int x, input int y);
    case (md)
      0: return ((x % G == 0) || (y % G == 0)) ? 16'hFFFF : 16'h0000;
      1: begin
        case ((x * 8) / H)
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2: return ((((x / G) ^ (y / G)) & 1) == 0) ? 16'hFFFF : 16'h0000;
      default: return c;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pix = 0; m_win = 0; m_pl = 0; m_mode = 0; m_color = 16'h0; m_done = 1'b0;
  endtask

  task automatic check_outputs();
    if (done === 1'b1) dut_frames++;
    chk("cyc",  32'(cyc),  32'(m_st == 1));
    chk("stb",  32'(stb),  32'(m_st == 1));
    chk("busy", 32'(busy), 32'(m_st != 0));
    chk("done", 32'(done), 32'(m_done));
    chk("adr",  adr,       BA + 32'(2 * m_pix));
    chk("dat",  32'(dat),  32'(pat(m_mode, m_color, m_pix % H, m_pix / H)));
  endtask

  // Called at a falling edge: check current outputs, drive inputs, advance model past the next rising edge.
  task automatic step(input bit e, input bit a, input logic [1:0] md, input logic [15:0] cl);
    check_outputs();
    en = e; ack = a; mode = md; color = cl;
    m_done = 1'b0;
    case (m_st)
      0: if (e) begin
        m_mode = int'(md); m_color = cl; m_pix = 0; m_win = 0; m_st = 1;
      end
      1: if (a) begin
        m_pix++;
        m_win++;
        if (m_pix == H * V) begin
          m_done = 1'b1; m_frames++; m_pix = 0; m_win = 0;
          if (e) begin
            m_mode = int'(md); m_color = cl; m_st = 2; m_pl = P;
          end else begin
            m_st = 0;
          end
        end else if (m_win == B) begin
          m_st = 2; m_pl = P;
        end
      end
      default: begin
        m_pl--;
        if (m_pl == 0) begin
          m_win = 0; m_st = 1;
        end
      end
    endcase
    @(negedge clk);
  endtask

  initial begin
    int n;
    m_frames = 0; dut_frames = 0;
    rst = 1'b1; en = 1'b0; ack = 1'b0; mode = 2'd0; color = 16'h0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("we",  32'(we),  32'd1);
    chk("sel", 32'(sel), 32'd3);
    chk("cti", 32'(cti), 32'd0);
    chk("bte", 32'(bte), 32'd0);
    repeat (2) step(1'b0, 1'b1, 2'd0, 16'h0);

    // grid, ack tied high
    repeat (110) step(1'b1, 1'b1, 2'd0, 16'h0);
    // colour bars
    repeat (150) step(1'b1, 1'b1, 2'd1, 16'h0);
    // deterministic wait states, then random ack with mode/colour churning mid-frame
    for (int k = 0; k < 300; k++)
      step(1'b1, (k % 3) == 2, 2'($urandom_range(0, 3)), 16'($urandom));
    for (int k = 0; k < 300; k++)
      step(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));

    // mode latch: checker frame in progress, then request solid 0x1234
    n = 0;
    while (!(m_mode == 2 && m_st == 1 && m_pix >= 3) && n < 400) begin
      step(1'b1, 1'($urandom_range(0, 1)), 2'd2, 16'h0);
      n++;
    end
    chk("reach_checker", 32'(m_mode == 2 && m_pix >= 3), 32'd1);
    repeat (200) step(1'b1, 1'($urandom_range(0, 1)), 2'd3, 16'h1234);
    chk("solid_latched", 32'(m_mode), 32'd3);

    // stop mid-frame: frame completes, then idle
    n = 0;
    while (!(m_st == 1 && m_pix > 5) && n < 400) begin
      step(1'b1, 1'b1, 2'd1, 16'h0);
      n++;
    end
    chk("reach_midframe", 32'(m_st == 1 && m_pix > 5), 32'd1);
    n = 0;
    while (m_st != 0 && n < 300) begin
      step(1'b0, 1'($urandom_range(0, 1)), 2'd1, 16'h0);
      n++;
    end
    chk("reach_idle", 32'(m_st), 32'd0);
    repeat (10) step(1'b0, 1'b1, 2'd2, 16'h0);

    // asynchronous reset in the middle of a write window
    n = 0;
    while (!(m_st == 1 && m_pix >= 3) && n < 400) begin
      step(1'b1, 1'b1, 2'd3, 16'hABCD);
      n++;
    end
    chk("reach_write", 32'(m_st == 1 && m_pix >= 3), 32'd1);
    chk("pre_rst_cyc", 32'(cyc), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_cyc",  32'(cyc),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_adr",  adr,       BA);
    chk("rst_dat",  32'(dat),  32'hFFFF);
    model_reset();
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) step(1'b0, 1'b1, 2'd0, 16'h0);

    chk("frame_count", 32'(dut_frames), 32'(m_frames));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
